// File: rtl/mac_shift_datapath.sv
// -----------------------------------------------------------------------------
// mac_shift_datapath
//
// Arithmetic back end of the audio mixer/DSP sequencer. It has three stages,
// each one register deep:
//    1. A 16x16 unsigned multiplier. Its result is registered into mul_out.
//    2. A signed add/subtract accumulator. It takes the mul_out register as its
//       operand, so the accumulate controls must arrive one cycle after a/b.
//    3. An arithmetic right shifter with 16-bit saturation. It takes the
//       acc_out register as its input and produces an audio sample.
// All state changes on the falling edge of ck. rst is synchronous and
// active-high, and it clears every register.
//
// Ports
//    ck         in   1        clock; registers update on negedge
//    rst        in   1        synchronous active-high reset, overrides all
//    a, b       in   16       unsigned multiplier operands
//    acc_en     in   1        accumulate the current mul_out this cycle
//    acc_clr    in   1        with acc_en: start a new sum from zero
//    acc_add    in   1        1 = add product, 0 = subtract product
//    shift_en   in   1        load the shifter output register this cycle
//    shift      in   SHIFT_W  arithmetic right-shift count applied to acc_out
//    mul_out    out  32       registered product a*b
//    acc_out    out  ACC_W    registered signed accumulator
//    shift_out  out  16       registered scaled and saturated sample
// -----------------------------------------------------------------------------
module mac_shift_datapath #(
   parameter int ACC_W   = 40,
   parameter int SHIFT_W = 4
) (
   input  logic               ck,
   input  logic               rst,
   input  logic [15:0]        a,
   input  logic [15:0]        b,
   input  logic               acc_en,
   input  logic               acc_clr,
   input  logic               acc_add,
   input  logic               shift_en,
   input  logic [SHIFT_W-1:0] shift,
   output logic [31:0]        mul_out,
   output logic [ACC_W-1:0]   acc_out,
   output logic [15:0]        shift_out
);

   // Saturation bounds, expressed at accumulator width so that the
   // comparisons below are full-width signed comparisons.
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   logic [31:0]        mul_reg;
   logic [ACC_W-1:0]   acc_reg;
   logic [15:0]        shift_reg;

   logic [31:0]        mul_next;
   logic [ACC_W-1:0]   product_ext;
   logic [ACC_W-1:0]   acc_base;
   logic [ACC_W-1:0]   acc_next;
   logic [15:0]        shift_next;

   // -------------------------------------------------------------------------
   // Multiplier: exact 32-bit unsigned product. It updates every cycle.
   // -------------------------------------------------------------------------
   assign mul_next = 32'(a) * 32'(b);

   // -------------------------------------------------------------------------
   // Accumulator. The product is treated as an unsigned magnitude: it is
   // zero-extended, then added or subtracted. A clear replaces the running sum
   // with zero before the product is applied. That gives +P or -P in one step.
   // Wrap-around is modulo 2^ACC_W and is intentionally not flagged.
   // -------------------------------------------------------------------------
   assign product_ext = ACC_W'(mul_reg);
   assign acc_base    = acc_clr ? '0 : acc_reg;
   assign acc_next    = acc_add ? (acc_base + product_ext)
                                : (acc_base - product_ext);

   // -------------------------------------------------------------------------
   // Logarithmic arithmetic shifter. Stage gi shifts by 2^gi when bit gi of
   // the count is set. The sign bit is replicated at every stage.
   // -------------------------------------------------------------------------
   logic signed [ACC_W-1:0] stage [0:SHIFT_W];

   assign stage[0] = $signed(acc_reg);

   generate
      for (genvar gi = 0; gi < SHIFT_W; gi++) begin : g_shift_stage
         assign stage[gi+1] = shift[gi] ? (stage[gi] >>> (2 ** gi))
                                        : stage[gi];
      end
   endgenerate

   // Clamp the shifted value to the signed 16-bit sample range.
   always_comb begin
      shift_next = stage[SHIFT_W][15:0];
      if (stage[SHIFT_W] > SAT_MAX) begin
         shift_next = 16'h7FFF;
      end else if (stage[SHIFT_W] < SAT_MIN) begin
         shift_next = 16'h8000;
      end
   end

   // -------------------------------------------------------------------------
   // Pipeline registers, all on the falling edge. Reset discards everything,
   // including a partial sum. The next accumulate therefore starts from zero
   // even without acc_clr.
   // -------------------------------------------------------------------------
   always_ff @(negedge ck) begin
      if (rst) begin
         mul_reg   <= '0;
         acc_reg   <= '0;
         shift_reg <= '0;
      end else begin
         mul_reg <= mul_next;
         if (acc_en) begin
            acc_reg <= acc_next;
         end
         if (shift_en) begin
            shift_reg <= shift_next;
         end
      end
   end

   assign mul_out   = mul_reg;
   assign acc_out   = acc_reg;
   assign shift_out = shift_reg;

endmodule

// File: tb/tb_mac_shift_datapath.sv
// -----------------------------------------------------------------------------
// tb_mac_shift_datapath
//
// Self-checking bench for mac_shift_datapath. A behavioural model advances on
// every falling edge, using plain integer arithmetic. A single compare process
// checks all three DUT outputs against that model on every rising edge, which
// is half a cycle away from the active edge. The stimulus process also posts
// hand-computed literal expectations into a one-entry slot. The same compare
// process checks them on the next rising edge.
// -----------------------------------------------------------------------------
module tb_mac_shift_datapath;

   localparam int ACC_W   = 40;
   localparam int SHIFT_W = 4;

   logic               ck = 1'b0;
   logic               rst;
   logic [15:0]        a;
   logic [15:0]        b;
   logic               acc_en;
   logic               acc_clr;
   logic               acc_add;
   logic               shift_en;
   logic [SHIFT_W-1:0] shift;
   logic [31:0]        mul_out;
   logic [ACC_W-1:0]   acc_out;
   logic [15:0]        shift_out;

   always #5 ck = ~ck;

   mac_shift_datapath #(
      .ACC_W   (ACC_W),
      .SHIFT_W (SHIFT_W)
   ) dut (
      .ck        (ck),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .acc_add   (acc_add),
      .shift_en  (shift_en),
      .shift     (shift),
      .mul_out   (mul_out),
      .acc_out   (acc_out),
      .shift_out (shift_out)
   );

   // ---------------------------------------------------------------- model
   logic [31:0]      m_mul;
   logic [ACC_W-1:0] m_acc;
   logic [15:0]      m_sh;
   bit               m_valid = 1'b0;
   longint           m_t;

   always @(negedge ck) begin
      if (rst) begin
         m_mul   = '0;
         m_acc   = '0;
         m_sh    = '0;
         m_valid = 1'b1;
      end else begin
         // Evaluate with the pre-edge values of each stage.
         if (shift_en) begin
            m_t  = longint'($signed(m_acc)) >>> shift;
            m_sh = (m_t > 32767) ? 16'h7FFF :
                   (m_t < -32768) ? 16'h8000 : 16'(m_t);
         end
         if (acc_en) begin
            if (acc_clr) m_acc = '0;
            if (acc_add) m_acc = m_acc + ACC_W'(m_mul);
            else         m_acc = m_acc - ACC_W'(m_mul);
         end
         m_mul = 32'(a) * 32'(b);
      end
   end

   // ------------------------------------------------- literal expectation slot
   int               lit_seq  = 0;
   int               lit_seen = 0;
   string            lit_name;
   logic [2:0]       lit_mask;
   logic [31:0]      lit_mul;
   logic [ACC_W-1:0] lit_acc;
   logic [15:0]      lit_sh;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // --------------------------------------------------------- compare process
   always @(posedge ck) begin
      if (m_valid) begin
         chk("model mul_out",   64'(mul_out),   64'(m_mul));
         chk("model acc_out",   64'(acc_out),   64'(m_acc));
         chk("model shift_out", 64'(shift_out), 64'(m_sh));
      end
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         if (lit_mask[2]) chk({lit_name, " mul_out"},   64'(mul_out),   64'(lit_mul));
         if (lit_mask[1]) chk({lit_name, " acc_out"},   64'(acc_out),   64'(lit_acc));
         if (lit_mask[0]) chk({lit_name, " shift_out"}, 64'(shift_out), 64'(lit_sh));
         $display("[TB] check %s: mul=%h acc=%h sh=%h", lit_name, mul_out, acc_out, shift_out);
      end
   end

   // ---------------------------------------------------------------- stimulus
   // One cycle: drive on the rising edge, then return just after the falling
   // (active) edge, so that the new DUT state is visible.
   task automatic cyc(input logic [15:0] ia, input logic [15:0] ib,
                      input logic en, input logic clr, input logic add,
                      input logic sen, input logic [SHIFT_W-1:0] sh);
      @(posedge ck);
      rst = 1'b0; a = ia; b = ib;
      acc_en = en; acc_clr = clr; acc_add = add;
      shift_en = sen; shift = sh;
      @(negedge ck);
      #1;
   endtask

   // Reset cycle. All other inputs are random, and both enables are asserted.
   task automatic rcyc();
      @(posedge ck);
      rst = 1'b1; a = 16'($urandom); b = 16'($urandom);
      acc_en = 1'b1; acc_clr = 1'($urandom); acc_add = 1'($urandom);
      shift_en = 1'b1; shift = SHIFT_W'($urandom);
      @(negedge ck);
      #1;
   endtask

   // Post one literal expectation. Call at most once per cyc/rcyc.
   task automatic expect_lit(input string nm, input logic [2:0] mask,
                             input logic [31:0] em, input logic [ACC_W-1:0] ea,
                             input logic [15:0] es);
      lit_name = nm; lit_mask = mask;
      lit_mul = em; lit_acc = ea; lit_sh = es;
      lit_seq++;
   endtask

   // Shifter table: product a*b, loaded with clear in add/sub, then shifted.
   logic [15:0]        st_a   [9] = '{16'd15, 16'd5, 16'd32, 16'd32, 16'd217,
                                      16'd128, 16'd128, 16'd3, 16'd3};
   logic [15:0]        st_b   [9] = '{16'd4971, 16'd10, 16'd32768, 16'd32768, 16'd151,
                                      16'd256, 16'd256, 16'd10923, 16'd10923};
   logic               st_add [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [SHIFT_W-1:0] st_sh  [9] = '{4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
   logic [15:0]        st_exp [9] = '{16'h1234, 16'hFFE7, 16'h7FFF, 16'h8000, 16'h7FFF,
                                      16'h7FFF, 16'h8000, 16'h8000, 16'h4000};

   initial begin
      rst = 1'b1; a = '0; b = '0;
      acc_en = 1'b0; acc_clr = 1'b0; acc_add = 1'b0;
      shift_en = 1'b0; shift = '0;

      // Reset, with random inputs and both enables asserted.
      rcyc();
      rcyc();
      expect_lit("reset", 3'b111, 32'd0, '0, 16'd0);

      // First inputs after reset, and the multiplier corners.
      cyc(16'd3, 16'd5, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
      expect_lit("mul 3x5", 3'b111, 32'd15, '0, 16'd0);
      cyc(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      expect_lit("mul ffff sq", 3'b111, 32'hFFFE_0001, 40'd15, 16'd0);
      cyc(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      expect_lit("first sample", 3'b111, 32'd0, 40'd15, 16'd15);

      // Accumulator sequence: +100, +50, -200, then hold.
      cyc(16'd10, 16'd10, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cyc(16'd5, 16'd10, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      expect_lit("acc clr+100", 3'b010, '0, 40'd100, '0);
      cyc(16'd10, 16'd20, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      expect_lit("acc +50", 3'b010, '0, 40'd150, '0);
      cyc(16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      expect_lit("acc -200", 3'b010, '0, 40'hFF_FFFF_FFCE, '0);
      for (int i = 0; i < 3; i++)
         cyc(16'($urandom), 16'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0, 4'd0);
      expect_lit("acc hold", 3'b010, '0, 40'hFF_FFFF_FFCE, '0);

      // Wrap: 512 * 2^30 = 2^39, minus 1 -> max positive, plus 1 -> wraps.
      cyc(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 512; i++)
         cyc((i == 511) ? 16'd1 : 16'h8000, (i == 511) ? 16'd1 : 16'h8000,
             1'b1, (i == 0), 1'b1, 1'b0, 4'd0);
      cyc(16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      expect_lit("acc max pos", 3'b010, '0, 40'h7F_FFFF_FFFF, '0);
      cyc(16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      expect_lit("acc wrap", 3'b010, '0, 40'h80_0000_0000, '0);
      cyc(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
      expect_lit("shift most neg", 3'b001, '0, '0, 16'h8000);

      // Shifter table: exact values and saturation boundaries.
      for (int i = 0; i < 9; i++) begin
         cyc(st_a[i], st_b[i], 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
         cyc(16'd0, 16'd0, 1'b1, 1'b1, st_add[i], 1'b0, 4'd0);
         cyc(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, st_sh[i]);
         expect_lit($sformatf("shift case %0d", i), 3'b001, '0, '0, st_exp[i]);
      end
      cyc(16'd9, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      cyc(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
      expect_lit("shift hold", 3'b001, '0, '0, 16'h4000);

      // Full pipeline: 1000*30 - 1000*10 = 20000.
      cyc(16'd1000, 16'd30, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cyc(16'd1000, 16'd10, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      cyc(16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      expect_lit("pipe acc", 3'b010, '0, 40'd20000, '0);
      cyc(16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      expect_lit("pipe sample", 3'b001, '0, '0, 16'h4E20);

      // Reset in the middle of a sum. The next accumulate starts from zero
      // even without a clear.
      cyc(16'd100, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cyc(16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      rcyc();
      expect_lit("mid-sum reset", 3'b111, 32'd0, '0, 16'd0);
      cyc(16'd7, 16'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      cyc(16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
      expect_lit("acc after reset", 3'b010, '0, 40'd49, '0);

      // Random traffic, with occasional resets, checked by the model.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            rcyc();
         end else begin
            cyc(16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                1'($urandom), 1'($urandom), SHIFT_W'($urandom));
         end
      end

      @(posedge ck);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
